// File: rtl/sayi_yukleyici_if.sv
// Operand-entry bus: switch/button/clear inputs toward the loader and the
// captured operands, enable and state back out toward the multiplier side.
interface sayi_yukleyici_if;
    logic [2:0] giris;
    logic       onay;
    logic       temizle;
    logic [2:0] sayi1;
    logic [2:0] sayi2;
    logic       en;
    logic [1:0] durum;

    // Drives the switches/button/clear and observes the operands.
    modport master (
        output giris,
        output onay,
        output temizle,
        input  sayi1,
        input  sayi2,
        input  en,
        input  durum
    );

    // The loader itself.
    modport slave (
        input  giris,
        input  onay,
        input  temizle,
        output sayi1,
        output sayi2,
        output en,
        output durum
    );
endinterface

// File: rtl/sayi_yukleyici.sv
// Operand loader for the 3-bit multiplier: synchronises and debounces the
// push-button, captures two operands on two presses, then holds them with en
// high until a new entry, a clear, or the optional display timeout.
//
// state | meaning
// ------+-----------------------------------------------------------
// BOS   | idle, no operand captured, en low
// ILK   | first operand held in sayi1, waiting for the second press
// HAZIR | both operands held, en high, display counter running
module sayi_yukleyici #(
    parameter int SUZGEC   = 4,
    parameter int GOSTERIM = 100
) (
    input logic             clk,
    input logic             rst,
    sayi_yukleyici_if.slave bus
);

    // A GOSTERIM of 0 still gets a 1-bit counter; it just never matches.
    localparam int GW = (GOSTERIM > 1) ? $clog2(GOSTERIM) : 1;
    localparam logic [7:0]    SUZ_SON = 8'(SUZGEC - 1);
    localparam logic [GW-1:0] GOS_SON = (GOSTERIM > 0) ? GW'(GOSTERIM - 1) : '0;
    localparam logic          GOS_VAR = (GOSTERIM != 0);

    typedef enum logic [1:0] {
        BOS   = 2'b00,
        ILK   = 2'b01,
        HAZIR = 2'b10
    } durum_t;

    logic          s1;
    logic          s2;
    logic          kararli;
    logic          kararli_d;
    logic [7:0]    sayac;
    logic          basma;
    logic          zaman_doldu;

    durum_t        durum_r;
    durum_t        durum_n;
    logic [2:0]    sayi1_r;
    logic [2:0]    sayi1_n;
    logic [2:0]    sayi2_r;
    logic [2:0]    sayi2_n;
    logic          en_r;
    logic          en_n;
    logic [GW-1:0] gcnt_r;
    logic [GW-1:0] gcnt_n;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.onay;
            s2 <= s1;
        end
    end

    // Debounce: the level is accepted only after SUZGEC consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kararli <= 1'b0;
            sayac   <= 8'd0;
        end else if (s2 == kararli) begin
            sayac <= 8'd0;
        end else if (sayac == SUZ_SON) begin
            kararli <= s2;
            sayac   <= 8'd0;
        end else begin
            sayac <= sayac + 8'd1;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kararli_d <= 1'b0;
        end else begin
            kararli_d <= kararli;
        end
    end

    // One-cycle pulse per accepted press; releases produce nothing.
    assign basma = kararli & ~kararli_d;

    // Timeout only exists when a finite display time was configured.
    assign zaman_doldu = GOS_VAR && (gcnt_r == GOS_SON);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_r <= BOS;
            sayi1_r <= 3'd0;
            sayi2_r <= 3'd0;
            en_r    <= 1'b0;
            gcnt_r  <= '0;
        end else begin
            durum_r <= durum_n;
            sayi1_r <= sayi1_n;
            sayi2_r <= sayi2_n;
            en_r    <= en_n;
            gcnt_r  <= gcnt_n;
        end
    end

    // Next state: clear beats a press, a press beats the timeout.
    always_comb begin
        durum_n = durum_r;
        if (bus.temizle) begin
            durum_n = BOS;
        end else begin
            unique case (durum_r)
                BOS: begin
                    if (basma) durum_n = ILK;
                end
                ILK: begin
                    if (basma) durum_n = HAZIR;
                end
                HAZIR: begin
                    if (basma) begin
                        durum_n = ILK;
                    end else if (zaman_doldu) begin
                        durum_n = BOS;
                    end
                end
                default: durum_n = BOS;
            endcase
        end
    end

    // Operand/enable/display-counter updates, same priority as the state.
    always_comb begin
        sayi1_n = sayi1_r;
        sayi2_n = sayi2_r;
        en_n    = en_r;
        gcnt_n  = gcnt_r;
        if (bus.temizle) begin
            sayi1_n = 3'd0;
            sayi2_n = 3'd0;
            en_n    = 1'b0;
            gcnt_n  = '0;
        end else begin
            unique case (durum_r)
                BOS: begin
                    en_n = 1'b0;
                    if (basma) sayi1_n = bus.giris;
                end
                ILK: begin
                    en_n = 1'b0;
                    if (basma) begin
                        sayi2_n = bus.giris;
                        en_n    = 1'b1;
                        gcnt_n  = '0;
                    end
                end
                HAZIR: begin
                    en_n = 1'b1;
                    // Saturate so an unbounded display never wraps into a match.
                    if (gcnt_r != '1) gcnt_n = gcnt_r + 1'b1;
                    if (basma) begin
                        sayi1_n = bus.giris;
                        sayi2_n = 3'd0;
                        en_n    = 1'b0;
                    end else if (zaman_doldu) begin
                        sayi1_n = 3'd0;
                        sayi2_n = 3'd0;
                        en_n    = 1'b0;
                    end
                end
                default: begin
                    sayi1_n = 3'd0;
                    sayi2_n = 3'd0;
                    en_n    = 1'b0;
                    gcnt_n  = '0;
                end
            endcase
        end
    end

    assign bus.sayi1 = sayi1_r;
    assign bus.sayi2 = sayi2_r;
    assign bus.en    = en_r;
    assign bus.durum = durum_r;

endmodule

// File: tb/tb_sayi_yukleyici.sv
// Bench for sayi_yukleyici: two instances (unbounded display and a 10-cycle
// display) share one button/switch stimulus; a press-level model predicts
// every output change with its clock edge, a monitor compares as they occur.
module tb_sayi_yukleyici;

    localparam int S  = 4;
    localparam int G0 = 0;
    localparam int G1 = 10;

    typedef struct {
        logic [8:0] tp;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;

    sayi_yukleyici_if if0 ();
    sayi_yukleyici_if if1 ();

    sayi_yukleyici #(.SUZGEC(S), .GOSTERIM(G0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    sayi_yukleyici #(.SUZGEC(S), .GOSTERIM(G1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    exp_t       q0[$];
    exp_t       q1[$];
    int         st[2];
    logic [2:0] ma[2];
    logic [2:0] mb[2];
    logic [8:0] last[2];
    logic [8:0] prev[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gval(input int k);
        return (k == 0) ? G0 : G1;
    endfunction

    // Model view of the outputs: {sayi1, sayi2, en, durum}.
    function automatic logic [8:0] tup(input int k);
        logic [1:0] d;
        d = 2'(st[k]);
        return {ma[k], mb[k], (st[k] == 2), d};
    endfunction

    task automatic push(input int k, input int t);
        exp_t e;
        logic [8:0] v;
        v = tup(k);
        if (v != last[k]) begin
            last[k] = v;
            e.tp  = v;
            e.cyc = t;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // A press taking effect at edge t; the finite-display instance is
    // expected to time out G edges after capture unless a reset intervenes.
    task automatic model_press(input int k, input int t, input logic [2:0] g, input bit kes);
        case (st[k])
            0: begin
                ma[k] = g; mb[k] = 3'd0; st[k] = 1;
                push(k, t);
            end
            1: begin
                mb[k] = g; st[k] = 2;
                push(k, t);
                if (gval(k) != 0 && !kes) begin
                    st[k] = 0; ma[k] = 3'd0; mb[k] = 3'd0;
                    push(k, t + gval(k));
                end
            end
            default: begin
                ma[k] = g; mb[k] = 3'd0; st[k] = 1;
                push(k, t);
            end
        endcase
    endtask

    task automatic model_clear(input int k, input int t);
        st[k] = 0; ma[k] = 3'd0; mb[k] = 3'd0;
        push(k, t);
    endtask

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, got, req, $time);
        end
    endtask

    task automatic mon(input int k, input logic [8:0] v);
        exp_t e;
        int   n;
        if (v !== prev[k]) begin
            prev[k] = v;
            checks++;
            n = (k == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                errors++;
                $display("FAIL dut%0d unexpected change: got %h at edge %0d, required no change", k, v, cyc);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                if (v !== e.tp || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL dut%0d output: got %h at edge %0d, required %h at edge %0d",
                             k, v, cyc, e.tp, e.cyc);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, {if0.sayi1, if0.sayi2, if0.en, if0.durum});
        mon(1, {if1.sayi1, if1.sayi2, if1.en, if1.durum});
    end

    task automatic set_giris(input logic [2:0] g);
        if0.giris = g;
        if1.giris = g;
    endtask

    task automatic set_onay(input logic v);
        if0.onay = v;
        if1.onay = v;
    endtask

    task automatic set_tem(input logic v);
        if0.temizle = v;
        if1.temizle = v;
    endtask

    // One button press with switches g. clr: temizle on the acting edge.
    // kes: asynchronous reset in HAZIR with the button still held.
    task automatic press(input logic [2:0] g, input bit clr, input bit kes);
        int c;
        int t;
        int r;
        @(negedge clk);
        c = cyc;
        t = c + 3 + S;
        set_giris(g);
        set_onay(1'b1);
        for (int k = 0; k < 2; k++) begin
            if (clr) model_clear(k, t);
            else     model_press(k, t, g, kes);
        end
        if (clr) begin
            repeat (2 + S) @(negedge clk);
            set_tem(1'b1);
            @(negedge clk);
            set_tem(1'b0);
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        end else if (kes) begin
            repeat (S + 5) @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            chk("async_rst_dut0", {if0.sayi1, if0.sayi2, if0.en, if0.durum}, 9'd0);
            chk("async_rst_dut1", {if1.sayi1, if1.sayi2, if1.en, if1.durum}, 9'd0);
            for (int k = 0; k < 2; k++) model_clear(k, cyc + 1);
            @(negedge clk);
            rst = 1'b0;
            r = cyc;
            for (int k = 0; k < 2; k++) model_press(k, r + 3 + S, g, 1'b0);
            repeat (S + 4) @(negedge clk);
        end else begin
            repeat (S + 4 + $urandom_range(0, 3)) @(negedge clk);
        end
        set_onay(1'b0);
        repeat (S + 16 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic glitch();
        @(negedge clk);
        set_onay(1'b1);
        repeat (S - 1) @(negedge clk);
        set_onay(1'b0);
        repeat (S + 6) @(negedge clk);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        set_tem(1'b1);
        for (int k = 0; k < 2; k++) model_clear(k, cyc + 1);
        @(negedge clk);
        set_tem(1'b0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        errors = 0;
        checks = 0;
        cyc    = 0;
        for (int k = 0; k < 2; k++) begin
            st[k] = 0; ma[k] = 3'd0; mb[k] = 3'd0;
            last[k] = 9'd0; prev[k] = 9'd0;
        end
        rst = 1'b1;
        set_giris(3'd0);
        set_onay(1'b0);
        set_tem(1'b0);
        repeat (3) @(negedge clk);
        chk("reset_dut0_sayi1", {6'd0, if0.sayi1}, 9'd0);
        chk("reset_dut0_sayi2", {6'd0, if0.sayi2}, 9'd0);
        chk("reset_dut0_en",    {8'd0, if0.en},    9'd0);
        chk("reset_dut0_durum", {7'd0, if0.durum}, 9'd0);
        chk("reset_dut1_sayi1", {6'd0, if1.sayi1}, 9'd0);
        chk("reset_dut1_sayi2", {6'd0, if1.sayi2}, 9'd0);
        chk("reset_dut1_en",    {8'd0, if1.en},    9'd0);
        chk("reset_dut1_durum", {7'd0, if1.durum}, 9'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic entry, glitch rejection, re-entry, timeout with 7/6.
        press(3'd3, 0, 0);
        press(3'd5, 0, 0);
        glitch();
        press(3'd1, 0, 0);
        press(3'd6, 0, 0);
        clear_pulse();
        press(3'd7, 0, 0);
        press(3'd6, 0, 0);
        clear_pulse();
        press(3'd2, 0, 0);
        press(3'd4, 0, 0);
        press(3'd1, 0, 0);
        press(3'd6, 0, 0);
        // Clear on the acting edge of the second press.
        clear_pulse();
        press(3'd5, 0, 0);
        press(3'd3, 1, 0);
        // Asynchronous reset mid-HAZIR with the button held through release.
        clear_pulse();
        press(3'd3, 0, 0);
        press(3'd4, 0, 1);

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      press(3'($urandom_range(0, 7)), 1, 0);
            else if (sel == 1) glitch();
            else if (sel == 2) clear_pulse();
            else               press(3'($urandom_range(0, 7)), 0, 0);
        end

        repeat (40) @(negedge clk);
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL dut0 pending: got %0d unseen changes, required 0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL dut1 pending: got %0d unseen changes, required 0", q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
